// File: rtl/alarm_zone_ctrl_if.sv
// Bundle of control, sensor, video and status signals for alarm_zone_ctrl.
// The master modport is the driver of the controls (top level / bench), the slave is the controller.
interface alarm_zone_ctrl_if #(
  parameter int NUM_ZONES = 4
);
  logic                 ena;
  logic                 arm;
  logic                 manual_reset;
  logic [NUM_ZONES-1:0] zone_in;
  logic [NUM_ZONES-1:0] zone_en;
  logic                 video_active;
  logic [9:0]           pix_x;
  logic [1:0]           R;
  logic [1:0]           G;
  logic [1:0]           B;
  logic [1:0]           state;
  logic [NUM_ZONES-1:0] tripped;
  logic                 alarm_active;

  modport master (
    output ena, arm, manual_reset, zone_in, zone_en, video_active, pix_x,
    input  R, G, B, state, tripped, alarm_active
  );

  modport slave (
    input  ena, arm, manual_reset, zone_in, zone_en, video_active, pix_x,
    output R, G, B, state, tripped, alarm_active
  );
endinterface

// File: rtl/alarm_zone_ctrl.sv
// Multi-zone alarm supervisor: arming FSM, trip latch and per-zone VGA status columns.
// Define ALARM_ENTRY_DELAY_EN to build the ENTRY state and its delay counter.
module alarm_zone_ctrl #(
  parameter int          NUM_ZONES   = 4,
  parameter logic [23:0] ENTRY_DELAY = 24'd12_000_000,
  parameter int          FLASH_BITS  = 23,
  parameter int          COL_SHIFT   = 7
) (
  input logic             clk,
  input logic             rst_n,
  alarm_zone_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_ENTRY    = 2'd2,
    S_ALARM    = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [NUM_ZONES-1:0]  tripped_reg, tripped_next;
  logic [NUM_ZONES-1:0]  sync_zone;
  logic [NUM_ZONES-1:0]  hit;
  logic [NUM_ZONES-1:0]  col_hit;
  logic [FLASH_BITS-1:0] flash_cnt_reg;
  logic                  flash;
  logic [9:0]            col;
  logic                  col_in_range, col_enabled, col_tripped;
  logic [1:0]            r_reg, g_reg, b_reg;
  logic [1:0]            r_next, g_next, b_next;

`ifdef ALARM_ENTRY_DELAY_EN
  logic [23:0] delay_reg, delay_next;
`endif

  // A zero delay would make ENTRY unrepresentable; refuse to elaborate.
  if (ENTRY_DELAY == 24'd0) begin : g_bad_entry_delay
    $error("ENTRY_DELAY must be at least 1");
  end

  assign col = bus.pix_x >> COL_SHIFT;

  for (genvar gi = 0; gi < NUM_ZONES; gi++) begin : g_zone
    logic s1_reg, s2_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_reg <= 1'b0;
        s2_reg <= 1'b0;
      end else if (bus.ena) begin
        s1_reg <= bus.zone_in[gi];
        s2_reg <= s1_reg;
      end
    end
    assign sync_zone[gi] = s2_reg;
    assign col_hit[gi]   = (col == 10'(gi));
  end

  assign hit          = sync_zone & bus.zone_en;
  assign flash        = flash_cnt_reg[FLASH_BITS-1];
  assign col_in_range = |col_hit;
  assign col_enabled  = |(col_hit & bus.zone_en);
  assign col_tripped  = |(col_hit & tripped_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_DISARMED;
      tripped_reg   <= '0;
      flash_cnt_reg <= '0;
      r_reg         <= 2'd0;
      g_reg         <= 2'd0;
      b_reg         <= 2'd0;
`ifdef ALARM_ENTRY_DELAY_EN
      delay_reg     <= 24'd0;
`endif
    end else if (bus.ena) begin
      state_reg     <= state_next;
      tripped_reg   <= tripped_next;
      flash_cnt_reg <= flash_cnt_reg + 1'b1;
      r_reg         <= r_next;
      g_reg         <= g_next;
      b_reg         <= b_next;
`ifdef ALARM_ENTRY_DELAY_EN
      delay_reg     <= delay_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    tripped_next = tripped_reg;
`ifdef ALARM_ENTRY_DELAY_EN
    delay_next   = delay_reg;
`endif
    if (bus.manual_reset) begin
      tripped_next = '0;
      state_next   = bus.arm ? S_ARMED : S_DISARMED;
`ifdef ALARM_ENTRY_DELAY_EN
      delay_next   = 24'd0;
`endif
    end else if (!bus.arm) begin
      state_next   = S_DISARMED;
      tripped_next = '0;
    end else begin
      case (state_reg)
        S_DISARMED: state_next = S_ARMED;
        S_ARMED: begin
          if (|hit) begin
            tripped_next = tripped_reg | hit;
`ifdef ALARM_ENTRY_DELAY_EN
            state_next   = S_ENTRY;
            delay_next   = ENTRY_DELAY - 24'd1;
`else
            state_next   = S_ALARM;
`endif
          end
        end
`ifdef ALARM_ENTRY_DELAY_EN
        // Re-trips only widen the mask; the countdown is never reloaded here.
        S_ENTRY: begin
          tripped_next = tripped_reg | hit;
          if (delay_reg == 24'd0) begin
            state_next = S_ALARM;
          end else begin
            delay_next = delay_reg - 24'd1;
          end
        end
`endif
        S_ALARM:    tripped_next = tripped_reg | hit;
        default:    state_next   = S_DISARMED;
      endcase
    end
  end

  always_comb begin
    r_next = 2'd0;
    g_next = 2'd0;
    b_next = 2'd0;
    if (bus.video_active && col_in_range) begin
      case (state_reg)
        S_DISARMED: b_next = 2'd3;
        S_ARMED: begin
          if (col_enabled) begin
            g_next = 2'd3;
          end else begin
            r_next = 2'd1;
            g_next = 2'd1;
            b_next = 2'd1;
          end
        end
        S_ENTRY: begin
          if (flash) begin
            r_next = 2'd3;
            g_next = 2'd3;
          end
        end
        S_ALARM: begin
          if (col_tripped) begin
            if (flash) r_next = 2'd3;
          end else if (col_enabled) begin
            g_next = 2'd3;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.state        = state_reg;
    bus.alarm_active = (state_reg == S_ALARM);
    bus.tripped      = tripped_reg;
    bus.R            = r_reg;
    bus.G            = g_reg;
    bus.B            = b_reg;
  end

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Scoreboard bench for alarm_zone_ctrl: a cycle-level reference model queues expectations,
// a monitor compares them one cycle-edge at a time. Follows ALARM_ENTRY_DELAY_EN like the RTL.
`timescale 1ns/1ps
module tb_alarm_zone_ctrl;
  localparam int NZ = 4;
  localparam int ED = 8;
  localparam int FB = 4;
  localparam int CS = 7;
`ifdef ALARM_ENTRY_DELAY_EN
  localparam bit ENTRY_EN = 1'b1;
`else
  localparam bit ENTRY_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alarm_zone_ctrl_if #(.NUM_ZONES(NZ)) bus ();

  alarm_zone_ctrl #(
    .NUM_ZONES  (NZ),
    .ENTRY_DELAY(24'(ED)),
    .FLASH_BITS (FB),
    .COL_SHIFT  (CS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0]    st;
    logic [NZ-1:0] tr;
    logic          aa;
    logic [1:0]    r;
    logic [1:0]    g;
    logic [1:0]    b;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: spec rules at cycle granularity, entry timed by elapsed cycles.
  int          m_state;
  logic [NZ-1:0] m_trip;
  logic [NZ-1:0] m_pipe[$];
  int          m_elapsed;
  int          m_flash;
  int          m_r, m_g, m_b;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_trip = '0; m_elapsed = 0; m_flash = 0;
    m_r = 0; m_g = 0; m_b = 0;
    m_pipe = '{'0, '0};
  endtask

  task automatic model_step();
    logic [NZ-1:0] hit;
    int col, flash, nr, ng, nb;
    if (!bus.ena) return;
    hit   = m_pipe[1] & bus.zone_en;
    flash = (m_flash >> (FB - 1)) & 1;
    col   = int'(bus.pix_x) >> CS;
    nr = 0; ng = 0; nb = 0;
    if (bus.video_active && col < NZ) begin
      if (m_state == 0) nb = 3;
      else if (m_state == 1) begin
        if (bus.zone_en[col]) ng = 3;
        else begin nr = 1; ng = 1; nb = 1; end
      end else if (m_state == 2) begin
        if (flash == 1) begin nr = 3; ng = 3; end
      end else begin
        if (m_trip[col]) begin if (flash == 1) nr = 3; end
        else if (bus.zone_en[col]) ng = 3;
      end
    end
    m_r = nr; m_g = ng; m_b = nb;
    if (bus.manual_reset) begin
      m_trip = '0; m_state = bus.arm ? 1 : 0; m_elapsed = 0;
    end else if (!bus.arm) begin
      m_state = 0; m_trip = '0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (hit != '0) begin
        m_trip |= hit; m_elapsed = 0;
        m_state = ENTRY_EN ? 2 : 3;
      end
    end else if (m_state == 2) begin
      m_trip |= hit;
      m_elapsed++;
      if (m_elapsed >= ED) m_state = 3;
    end else begin
      m_trip |= hit;
    end
    m_pipe = '{bus.zone_in, m_pipe[0]};
    m_flash = (m_flash + 1) % (1 << FB);
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    e.st = 2'(m_state); e.tr = m_trip; e.aa = (m_state == 3);
    e.r = 2'(m_r); e.g = 2'(m_g); e.b = 2'(m_b);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("state",        int'(bus.state),        int'(mon_e.st));
      chk("tripped",      int'(bus.tripped),      int'(mon_e.tr));
      chk("alarm_active", int'(bus.alarm_active), int'(mon_e.aa));
      chk("R",            int'(bus.R),            int'(mon_e.r));
      chk("G",            int'(bus.G),            int'(mon_e.g));
      chk("B",            int'(bus.B),            int'(mon_e.b));
    end
  end

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_state"},   int'(bus.state),   0);
    chk({tag, "_tripped"}, int'(bus.tripped), 0);
    chk({tag, "_rgb"},     int'({bus.R, bus.G, bus.B}), 0);
    chk({tag, "_alarm"},   int'(bus.alarm_active), 0);
  endtask

  task automatic phase_done(input string name);
    $display("phase %-10s state=%0d tripped=%b model_state=%0d", name, bus.state, bus.tripped, m_state);
  endtask

  initial begin
    bus.ena = 1'b1; bus.arm = 1'b1; bus.manual_reset = 1'b0;
    bus.zone_in = '1; bus.zone_en = '1; bus.video_active = 1'b1; bus.pix_x = 10'd10;
    model_reset();
    @(negedge clk);
    async_reset_check("reset_hold");
    cycles(4);
    rst_n = 1'b1; bus.zone_in = '0;
    cycle();
    chk("reset_release_state", int'(bus.state), 1);
    cycles(3);
    phase_done("reset");

    // Entry delay: single-cycle pulse on zone 2
    bus.zone_in = 4'b0100; cycle();
    bus.zone_in = '0; cycles(ED + 6);
    phase_done("entry");

    // Bypass: disarm, rearm with zone 2 masked and held high
    bus.arm = 1'b0; cycle();
    bus.arm = 1'b1; bus.zone_en = 4'b1011; bus.zone_in = 4'b0100; bus.pix_x = 10'd300;
    cycles(8);
    chk("bypass_state", int'(bus.state), 1);
    chk("bypass_grey",  int'({bus.R, bus.G, bus.B}), 6'b01_01_01);
    phase_done("bypass");

    // Trip zone 0, then sweep columns/blanking across flash phases in ALARM
    bus.zone_in = 4'b0001; cycle();
    bus.zone_in = '0; cycles(ED + 4);
    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0: bus.pix_x = 10'd10;
        1: bus.pix_x = 10'd200;
        2: bus.pix_x = 10'd600;
        default: bus.pix_x = 10'd300;
      endcase
      bus.video_active = (i % 7) != 6;
      cycle();
    end
    bus.video_active = 1'b1;
    phase_done("display");

    // Priority: manual_reset alongside a fresh trip reaching the synchroniser output
    bus.zone_in = 4'b0001; cycles(2);
    bus.manual_reset = 1'b1; cycle();
    bus.manual_reset = 1'b0; bus.zone_in = '0;
    chk("priority_state", int'(bus.state), 1);
    chk("priority_trip",  int'(bus.tripped), 0);
    cycles(4);
    phase_done("priority");

    // Simultaneous trips, then ena dropped mid-entry
    bus.zone_en = '1; bus.zone_in = 4'b1011; cycle();
    bus.zone_in = '0; cycles(4);
    bus.ena = 1'b0; cycles(5);
    bus.ena = 1'b1; cycles(ED + 2);
    phase_done("ena_hold");

    // Asynchronous reset mid-operation, away from any clock edge
    async_reset_check("reset_async");
    cycles(2);
    rst_n = 1'b1; cycles(2);
    phase_done("async_rst");

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      bus.ena          = ($urandom_range(0, 9) != 0);
      bus.arm          = ($urandom_range(0, 49) != 0);
      bus.manual_reset = ($urandom_range(0, 59) == 0);
      for (int z = 0; z < NZ; z++) bus.zone_in[z] = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) bus.zone_en = NZ'($urandom);
      bus.video_active = ($urandom_range(0, 3) != 0);
      bus.pix_x        = 10'($urandom);
      cycle();
    end
    phase_done("random");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_zone_ctrl.md
# alarm_zone_ctrl

Parametrised multi-zone successor to the single-zone VGA alarm panel: supervises `NUM_ZONES` sensor inputs through a four-state arming machine with an optional entry delay, latches which zones tripped, and renders per-zone status columns onto the VGA pixel stream. It sits between the top-level `ui_in` pins and the shared `hvsync_generator`. It consumes `video_active`/`pix_x` from that generator and drives registered 2-bit-per-channel colour.

## Interface
- `NUM_ZONES`, 4: sensor zone count, 1..8.
- `ENTRY_DELAY`, 24'd12_000_000: cycles spent in ENTRY before ALARM, must be ≥1.
- `FLASH_BITS`, 23: flash counter width; flash phase = counter MSB.
- `COL_SHIFT`, 7: column index = `pix_x >> COL_SHIFT`, giving 128 px columns by default.
- `clk`  in  1  system/pixel clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  global enable; when low, every register holds.
- `arm`  in  1  arm request (level).
- `manual_reset`  in  1  clears alarm and tripped mask (level).
- `zone_in`  in  NUM_ZONES  raw asynchronous sensor levels, active-high.
- `zone_en`  in  NUM_ZONES  per-zone bypass mask; 0 ignores that zone.
- `video_active`  in  1  display-on from the sync generator.
- `pix_x`  in  10  current horizontal pixel.
- `R`, `G`, `B`  out  2 each  registered colour.
- `state`  out  2  0 DISARMED, 1 ARMED, 2 ENTRY, 3 ALARM.
- `tripped`  out  NUM_ZONES  latched trip mask.
- `alarm_active`  out  1  high exactly when `state`==ALARM.

## Operation
- Each `zone_in` bit passes through a 2-flop synchroniser.
- `hit` = synced zones & `zone_en`.
- Priority each enabled cycle: `manual_reset` > `!arm` > trip logic.
- `manual_reset`=1 → `tripped` cleared. State goes to ARMED if `arm`, else DISARMED. Delay counter cleared.
- `arm`=0 → DISARMED, `tripped` cleared.
- DISARMED: `arm`=1 → ARMED.
- ARMED: `hit`≠0 → `tripped` |= `hit`, then ENTRY (or ALARM, see Configuration). Delay counter loaded with ENTRY_DELAY-1.
- ENTRY: `tripped` |= `hit`. The counter decrements each cycle; the transition from 0 goes to ALARM.
- ALARM: `tripped` |= `hit`. The state stays in ALARM until `manual_reset` or `!arm`.
- Flash counter: free-running `FLASH_BITS` counter that wraps at all-ones to 0. `flash` = MSB.
- Colour, registered, evaluated from the current state:
  - `video_active`=0 → all 0.
  - Column `c` = `pix_x >> COL_SHIFT`. If c ≥ NUM_ZONES → 0.
  - DISARMED: B=3.
  - ARMED: G=3 if `zone_en[c]`, else R=1 G=1 B=1 (grey).
  - ENTRY: R=3 G=3 (yellow) when `flash`, else 0.
  - ALARM: R=3 for a tripped column when `flash`, else 0. Untripped enabled column G=3.

## Timing
- Reset values: `state`=0, `tripped`=0, `alarm_active`=0, R/G/B=0, all counters and synchroniser flops 0.
- Sensor → `state` latency: a rising `zone_in` at edge n appears in `state`/`tripped` after edge n+3 (2 sync + 1 state).
- ENTRY lasts exactly ENTRY_DELAY cycles. `alarm_active` rises ENTRY_DELAY cycles after `state` first reads 2.
- Colour output lags its inputs (`pix_x`, `video_active`, state) by 1 cycle.
- A trip arriving on the same cycle as `manual_reset` is discarded.
- Simultaneous trips on multiple zones all latch.
- Re-trips during ENTRY do not restart the counter.
- `ena` low mid-ENTRY freezes the counter. Counting resumes with no lost cycles.
- `rst_n` low at any point clears everything immediately, without waiting for a clock edge.

## Configuration
- `ALARM_ENTRY_DELAY_EN` defined: ENTRY state and delay counter exist as described.
- Not defined: ARMED goes directly to ALARM on `hit`≠0. Encoding 2 is never produced. The counter is not synthesised. `ENTRY_DELAY` is ignored.

## Test plan
Unless stated: NUM_ZONES=4, ENTRY_DELAY=8, FLASH_BITS=4, macro defined.
- Reset: hold `rst_n`=0 with `arm`=1 and `zone_in`=4'hF → `state`=0, `tripped`=0, RGB=0. Release, then 1 edge → `state`=1.
- Entry delay: armed, pulse `zone_in[2]` for 1 cycle → `state`=2 at +3 edges, `tripped`=4'b0100. `state`=3 exactly 8 cycles later.
- Bypass: `zone_en`=4'b1011, `zone_in[2]`=1 → `state` stays 1. Column 2 pixel (`pix_x`=300) renders grey 1/1/1.
- Priority: in ALARM, assert `manual_reset` and `zone_in[0]` together → `state`=1, `tripped`=0 next edge.
- Display: in ALARM with `tripped`=4'b0001 and `flash`=1 → `pix_x`=10 gives R=3, `pix_x`=200 gives G=3, `pix_x`=600 gives 0. `video_active`=0 gives 0.
- Macro off: armed, trip zone 1 → `state`=3 at +3 edges. Never observe 2.
